// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive protocol checker for the traffic-light controller bus
//
// Watches the 8-bit lights bus, decodes both direction nibbles and flags
// illegal phase sequencing, conflicting greens, invalid encodings, short
// greens and slow emergency response.
//
// Optional feature macro: TL_MON_PED_EN (walk-bit checking).
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   emg        - emergency request seen by the controller
//   lights     - controller output, [7:4] direction A, [3:0] direction B
//                (bit3 walk, bit2 red, bit1 yellow, bit0 green)
//   clr_err    - clears the sticky error flags
//   err_pulse  - one-cycle strobes {emg, short, seq, onehot, conflict}
//   err_sticky - accumulated err_pulse, same order
//   phase_a/b  - decoded phase: 0 red, 1 green, 2 yellow, 3 invalid
//   last_green - duration of the last completed green on direction A
//   cycle_cnt  - completed A red->green transitions (wraps)

module traffic_light_monitor #(
  parameter int MIN_GREEN = 8,
  parameter int EMG_LAT   = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          emg,
  input  logic [7:0]    lights,
  input  logic          clr_err,
  output logic [4:0]    err_pulse,
  output logic [4:0]    err_sticky,
  output logic [1:0]    phase_a,
  output logic [1:0]    phase_b,
  output logic [CW-1:0] last_green,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {INIT, RED, GREEN, YELLOW} state_t;

  localparam logic [1:0] PH_RED    = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_BAD    = 2'd3;

  // Sample pipeline; v_q marks that l_q holds a real post-reset sample so the
  // reset value of l_q is never decoded as an invalid nibble.
  logic [7:0]    l_q;
  logic          e_q;
  logic          e_qq;
  logic          v_q;

  state_t        st_a;
  state_t        st_b;
  logic [CW-1:0] gt_a;
  logic [CW-1:0] gt_b;
  logic [CW-1:0] emg_cnt;
  logic          emg_mode;
  logic          emg_done;

  function automatic logic [1:0] decode(input logic [3:0] n);
    case (n[2:0])
      3'b100:  return PH_RED;
      3'b001:  return PH_GREEN;
      3'b010:  return PH_YELLOW;
      default: return PH_BAD;
    endcase
  endfunction

  function automatic state_t to_state(input logic [1:0] p);
    case (p)
      PH_RED:   return RED;
      PH_GREEN: return GREEN;
      default:  return YELLOW;
    endcase
  endfunction

  // Each settled state has exactly one forbidden successor among the valid
  // phases; GREEN->RED is forgiven while an emergency is being served.
  function automatic logic illegal(input state_t s, input logic [1:0] p, input logic act);
    logic bad;
    bad = 1'b0;
    if (p != PH_BAD) begin
      case (s)
        RED:     bad = (p == PH_YELLOW);
        GREEN:   bad = (p == PH_RED) && !act;
        YELLOW:  bad = (p == PH_GREEN);
        default: bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  logic [1:0]    pa;
  logic [1:0]    pb;
  logic          e_rise;
  logic          emg_act;
  logic          walk_bad;
  logic          walk_clear;
  logic          all_red;
  logic          seq_a;
  logic          seq_b;
  logic          onehot;
  logic          conflict;
  logic          leave_a;
  logic          leave_b;
  logic          short_a;
  logic          short_b;
  logic [CW-1:0] cnt_k;
  logic          emg_check;
  logic          emg_fire;
  logic          cyc_inc;
  logic [4:0]    pulse;

`ifdef TL_MON_PED_EN
  // Walk is only legal while the same direction shows red.
  assign walk_bad   = (l_q[7] && (pa != PH_RED)) || (l_q[3] && (pb != PH_RED));
  assign walk_clear = !l_q[7] && !l_q[3];
`else
  logic unused_walk;
  assign walk_bad    = 1'b0;
  assign walk_clear  = 1'b1;
  assign unused_walk = l_q[7] ^ l_q[3];
`endif

  assign pa       = decode(l_q[7:4]);
  assign pb       = decode(l_q[3:0]);
  assign e_rise   = e_q && !e_qq;
  // A rising request counts as emergency in the same cycle it is detected.
  assign emg_act  = emg_mode || e_rise;
  assign all_red  = (pa == PH_RED) && (pb == PH_RED) && walk_clear;

  assign seq_a    = (st_a != INIT) && illegal(st_a, pa, emg_act);
  assign seq_b    = (st_b != INIT) && illegal(st_b, pb, emg_act);
  assign onehot   = (pa == PH_BAD) || (pb == PH_BAD);
  assign conflict = ((pa != PH_RED) && (pb != PH_RED)) || walk_bad;

  assign leave_a  = (st_a == GREEN) && (pa != PH_BAD) && (pa != PH_GREEN);
  assign leave_b  = (st_b == GREEN) && (pb != PH_BAD) && (pb != PH_GREEN);
  assign short_a  = leave_a && (gt_a < CW'(MIN_GREEN)) && !emg_act;
  assign short_b  = leave_b && (gt_b < CW'(MIN_GREEN)) && !emg_act;

  // cnt_k is the number of samples since the request rose, for this sample.
  assign cnt_k     = e_rise ? '0 : emg_cnt + CW'(1);
  assign emg_check = emg_act && (e_rise || !emg_done);
  assign emg_fire  = emg_check && !all_red && (cnt_k == CW'(EMG_LAT));

  assign cyc_inc  = (st_a == RED) && (pa == PH_GREEN) && !(seq_a || seq_b);

  assign pulse = v_q ? {emg_fire, short_a || short_b, seq_a || seq_b, onehot, conflict} : 5'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q        <= '0;
      e_q        <= 1'b0;
      e_qq       <= 1'b0;
      v_q        <= 1'b0;
      st_a       <= INIT;
      st_b       <= INIT;
      gt_a       <= '0;
      gt_b       <= '0;
      emg_cnt    <= '0;
      emg_mode   <= 1'b0;
      emg_done   <= 1'b0;
      err_pulse  <= '0;
      err_sticky <= '0;
      phase_a    <= PH_RED;
      phase_b    <= PH_RED;
      last_green <= '0;
      cycle_cnt  <= '0;
    end else begin
      l_q  <= lights;
      e_q  <= emg;
      e_qq <= e_q;
      v_q  <= 1'b1;

      err_pulse  <= pulse;
      // A pulse in the clearing cycle still lands in the sticky flags.
      err_sticky <= (clr_err ? 5'b0 : err_sticky) | pulse;

      if (v_q) begin
        phase_a <= pa;
        phase_b <= pb;

        if (pa != PH_BAD) st_a <= to_state(pa);
        if (pb != PH_BAD) st_b <= to_state(pb);

        if ((pa == PH_GREEN) && (st_a != GREEN)) gt_a <= CW'(1);
        else if ((st_a == GREEN) && !leave_a)    gt_a <= sat_inc(gt_a);
        if ((pb == PH_GREEN) && (st_b != GREEN)) gt_b <= CW'(1);
        else if ((st_b == GREEN) && !leave_b)    gt_b <= sat_inc(gt_b);

        if (leave_a) last_green <= gt_a;
        if (cyc_inc) cycle_cnt  <= cycle_cnt + CW'(1);

        if (emg_check) begin
          emg_cnt <= cnt_k;
          if (all_red || emg_fire) emg_done <= 1'b1;
          else if (e_rise)         emg_done <= 1'b0;
        end

        if (e_rise)                            emg_mode <= 1'b1;
        else if (emg_mode && !e_q && all_red) emg_mode <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - self-checking bench for traffic_light_monitor

module tb_traffic_light_monitor;

  localparam int MIN_GREEN = 8;
  localparam int EMG_LAT   = 4;
  localparam int CW        = 16;
  localparam int MAXV      = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          emg;
  logic [7:0]    lights;
  logic          clr_err;
  logic [4:0]    err_pulse;
  logic [4:0]    err_sticky;
  logic [1:0]    phase_a;
  logic [1:0]    phase_b;
  logic [CW-1:0] last_green;
  logic [CW-1:0] cycle_cnt;

  traffic_light_monitor #(.MIN_GREEN(MIN_GREEN), .EMG_LAT(EMG_LAT), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .emg        (emg),
    .lights     (lights),
    .clr_err    (clr_err),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .phase_a    (phase_a),
    .phase_b    (phase_b),
    .last_green (last_green),
    .cycle_cnt  (cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int emg_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase of a nibble: exactly one of red/yellow/green lit, else invalid.
  function automatic int dec(input logic [3:0] n);
    if ($countones(n[2:0]) != 1) return 3;
    if (n[2]) return 0;
    if (n[0]) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] nib(input int p);
    case (p)
      0:       return 4'b0100;
      1:       return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  // ---------------- behavioural reference ----------------
  // Phase history per direction is the last valid phase seen (-1 = none);
  // green durations come from the sample index at which green began.
  logic          model_ok = 1'b0;
  logic [7:0]    m_lq;
  logic          m_eq, m_eqq, m_v, m_mode, m_done;
  int            m_prev [2];
  int            m_gstart [2];
  int            m_t, m_rise_t;
  logic [4:0]    exp_pulse, exp_sticky;
  logic [1:0]    exp_pa, exp_pb;
  logic [CW-1:0] exp_lg, exp_cc;
  int            ph [2];
  int            dur, k;
  logic          rise, act, allred, seqv, shortv, fire, clear;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1;
      m_lq = '0; m_eq = 0; m_eqq = 0; m_v = 0; m_mode = 0; m_done = 0;
      m_prev[0] = -1; m_prev[1] = -1; m_gstart[0] = 0; m_gstart[1] = 0;
      m_t = 0; m_rise_t = 0;
      exp_pulse = '0; exp_sticky = '0; exp_pa = '0; exp_pb = '0;
      exp_lg = '0; exp_cc = '0;
    end else begin
      exp_pulse = '0;
      if (m_v) begin
        ph[0] = dec(m_lq[7:4]);
        ph[1] = dec(m_lq[3:0]);
        rise   = m_eq && !m_eqq;
        act    = m_mode || rise;
        allred = (ph[0] == 0) && (ph[1] == 0);
        seqv = 0; shortv = 0; fire = 0;
        for (int d = 0; d < 2; d++) begin
          if (ph[d] != 3) begin
            if (m_prev[d] >= 0 && ph[d] != m_prev[d]) begin
              if (!(ph[d] == (m_prev[d] + 1) % 3 || (act && m_prev[d] == 1 && ph[d] == 0)))
                seqv = 1;
            end
            if (m_prev[d] == 1 && ph[d] != 1) begin
              dur = m_t - m_gstart[d];
              if (dur > MAXV) dur = MAXV;
              if (d == 0) exp_lg = CW'(dur);
              if (dur < MIN_GREEN && !act) shortv = 1;
            end
            if (ph[d] == 1 && m_prev[d] != 1) m_gstart[d] = m_t;
          end
        end
        if (m_prev[0] == 0 && ph[0] == 1 && !seqv) exp_cc = exp_cc + 1'b1;
        for (int d = 0; d < 2; d++) if (ph[d] != 3) m_prev[d] = ph[d];

        clear = m_mode && !m_eq && allred;
        if (rise) begin
          m_rise_t = m_t; m_done = 0; m_mode = 1;
        end else if (clear) begin
          m_mode = 0;
        end
        if (act && !m_done) begin
          k = m_t - m_rise_t;
          if (allred) m_done = 1;
          else if (k == EMG_LAT) begin
            fire = 1; m_done = 1;
          end
        end

        exp_pulse = {fire, shortv, seqv, (ph[0] == 3 || ph[1] == 3), (ph[0] != 0 && ph[1] != 0)};
        exp_pa = 2'(ph[0]);
        exp_pb = 2'(ph[1]);
        m_t++;
      end
      exp_sticky = (clr_err ? 5'b0 : exp_sticky) | exp_pulse;
      m_eqq = m_eq; m_eq = emg; m_lq = lights; m_v = 1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("err_pulse",  32'(err_pulse),  32'(exp_pulse));
      chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
      chk("phase_a",    32'(phase_a),    32'(exp_pa));
      chk("phase_b",    32'(phase_b),    32'(exp_pb));
      chk("last_green", 32'(last_green), 32'(exp_lg));
      chk("cycle_cnt",  32'(cycle_cnt),  32'(exp_cc));
    end
  end

  // Present one lights/emg value for n samples; called at a negedge.
  task automatic hold(input logic [7:0] l, input logic e, input int n);
    lights = l;
    emg = e;
    repeat (n) begin
      @(negedge clk);
      if (err_pulse[4]) emg_seen++;
    end
  endtask

  localparam logic [7:0] RR = 8'h44, GR = 8'h14, YR = 8'h24, RG = 8'h41, RY = 8'h42;

  int a_ph, b_ph, r, len;
  logic [7:0] lv;
  logic ev;

  initial begin
    rst = 1'b1; emg = 1'b0; lights = RR; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset err_pulse",  32'(err_pulse), 0);
    chk("reset err_sticky", 32'(err_sticky), 0);
    chk("reset last_green", 32'(last_green), 0);
    chk("reset cycle_cnt",  32'(cycle_cnt), 0);
    rst = 1'b0;

    // Legal cycle
    hold(RR, 0, 2); hold(GR, 0, 10); hold(YR, 0, 3);
    hold(RG, 0, 10); hold(RY, 0, 3); hold(RR, 0, 2);
    chk("legal last_green", 32'(last_green), 10);
    chk("legal cycle_cnt",  32'(cycle_cnt), 1);
    chk("legal sticky",     32'(err_sticky), 0);

    // Short green
    hold(GR, 0, 5); hold(YR, 0, 1); hold(YR, 0, 1);
    chk("short pulse",      32'(err_pulse), 32'h08);
    chk("short last_green", 32'(last_green), 5);
    hold(YR, 0, 1);
    chk("short one cycle",  32'(err_pulse), 0);
    hold(RR, 0, 2);
    chk("short cycle_cnt",  32'(cycle_cnt), 2);
    clr_err = 1'b1; hold(RR, 0, 1); clr_err = 1'b0;
    chk("clr sticky", 32'(err_sticky), 0);

    // Conflict
    hold(8'h11, 0, 1); hold(8'h11, 0, 1);
    chk("conflict pulse", 32'(err_pulse[0]), 1);
    hold(8'h12, 0, 1); hold(8'h14, 0, 3);
    chk("conflict released", 32'(err_pulse[0]), 0);
    chk("conflict sticky",   32'(err_sticky[0]), 1);
    hold(YR, 0, 1); hold(RR, 0, 2);
    clr_err = 1'b1; hold(RR, 0, 1); clr_err = 1'b0;
    chk("conflict cleared", 32'(err_sticky), 0);

    // Illegal sequence and invalid encoding
    hold(YR, 0, 1); hold(YR, 0, 1);
    chk("seq pulse", 32'(err_pulse), 32'h04);
    hold(YR, 0, 1);
    chk("seq single", 32'(err_pulse), 0);
    hold(RR, 0, 2);
    hold(8'h64, 0, 1); hold(8'h64, 0, 1);
    chk("onehot pulse", 32'(err_pulse), 32'h02);
    chk("onehot phase", 32'(phase_a), 3);
    hold(RR, 0, 2);
    clr_err = 1'b1; hold(RR, 0, 1); clr_err = 1'b0;

    // Emergency served in time
    hold(GR, 0, 3); hold(GR, 1, 3); hold(RR, 1, 2); hold(RR, 0, 2);
    chk("emg on time sticky", 32'(err_sticky), 0);

    // Emergency served late
    emg_seen = 0;
    hold(GR, 0, 3); hold(GR, 1, 6); hold(RR, 1, 1); hold(RR, 0, 3);
    chk("emg late count",  emg_seen, 1);
    chk("emg late sticky", 32'(err_sticky), 32'h10);

    // Reset mid-green
    hold(GR, 0, 3);
    rst = 1'b1; hold(GR, 0, 1);
    chk("rst err_pulse",  32'(err_pulse), 0);
    chk("rst err_sticky", 32'(err_sticky), 0);
    chk("rst phase_a",    32'(phase_a), 0);
    chk("rst last_green", 32'(last_green), 0);
    chk("rst cycle_cnt",  32'(cycle_cnt), 0);
    rst = 1'b0;
    hold(GR, 0, 2);
    chk("post rst phase_a", 32'(phase_a), 1);
    chk("post rst no seq",  32'(err_sticky), 0);
    hold(GR, 0, 7); hold(YR, 0, 2);
    chk("post rst last_green", 32'(last_green), 9);
    chk("post rst cycle_cnt",  32'(cycle_cnt), 0);
    hold(RR, 0, 2);

    // Randomized traffic
    a_ph = 0; b_ph = 0; ev = 1'b0;
    for (int seg = 0; seg < 400; seg++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(1, 12);
      if (r < 50) begin
        if ($urandom_range(0, 1) == 1) a_ph = (a_ph + 1) % 3;
        else b_ph = (b_ph + 1) % 3;
        lv = {nib(a_ph), nib(b_ph)};
      end else if (r < 70) begin
        a_ph = $urandom_range(0, 2);
        b_ph = $urandom_range(0, 2);
        lv = {nib(a_ph), nib(b_ph)};
      end else if (r < 80) begin
        lv = 8'($urandom);
        len = $urandom_range(1, 3);
      end else if (r < 95) begin
        ev = ~ev;
        lv = {nib(a_ph), nib(b_ph)};
      end else begin
        a_ph = 0; b_ph = 0;
        lv = RR;
      end
      clr_err = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) == 0);
      hold(lv, ev, len);
      rst = 1'b0;
      clr_err = 1'b0;
    end
    hold(RR, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
